// File: rtl/care_pkg.sv
// Shared definitions for the care-action scheduler: action indices, widths, FSM states
// and one-hot helpers used by care_scheduler and care_rr_arbiter.
package care_pkg;
    localparam int NUM_ACT = 6;
    localparam int STAT_W  = 4;
    localparam int IDX_W   = 3;
    localparam int BUS_W   = 8;

    localparam logic [IDX_W-1:0] ACT_FEED   = 3'd0;
    localparam logic [IDX_W-1:0] ACT_PLAY   = 3'd1;
    localparam logic [IDX_W-1:0] ACT_HEAL   = 3'd2;
    localparam logic [IDX_W-1:0] ACT_CLEAN  = 3'd3;
    localparam logic [IDX_W-1:0] ACT_REST   = 3'd4;
    localparam logic [IDX_W-1:0] ACT_SOCIAL = 3'd5;
    localparam logic [IDX_W-1:0] ACT_NONE   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_COOL
    } state_t;

    function automatic logic [NUM_ACT-1:0] act_mask(input logic [IDX_W-1:0] idx);
        act_mask      = '0;
        act_mask[idx] = 1'b1;
    endfunction

    function automatic logic [BUS_W-1:0] bus_onehot(input logic [IDX_W-1:0] idx);
        bus_onehot      = '0;
        bus_onehot[idx] = 1'b1;
    endfunction
endpackage

// File: rtl/care_rr_arbiter.sv
// Combinational masked round-robin pick over the eligible actions, starting at rr_ptr.
// With CARE_URGENCY_PRIO_EN defined, the highest stat level wins and round-robin order breaks ties.
module care_rr_arbiter
    import care_pkg::*;
(
    input  logic [NUM_ACT-1:0]        elig,
    input  logic [IDX_W-1:0]          rr_ptr,
    input  logic [NUM_ACT*STAT_W-1:0] lvl,
    output logic                      valid,
    output logic [IDX_W-1:0]          idx
);
    localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_ACT);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] pos;

`ifdef CARE_URGENCY_PRIO_EN
    logic [STAT_W-1:0] lv [NUM_ACT];
    logic [STAT_W-1:0] best;

    for (genvar g = 0; g < NUM_ACT; g++) begin : g_lv
        assign lv[g] = lvl[g*STAT_W +: STAT_W];
    end

    // Walk in round-robin order; only a strictly higher level displaces the current pick.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        best  = '0;
        sum   = '0;
        pos   = '0;
        for (int k = 0; k < NUM_ACT; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= NUM_W) sum = sum - NUM_W;
            pos = sum[IDX_W-1:0];
            if (elig[pos] && (!valid || lv[pos] > best)) begin
                valid = 1'b1;
                idx   = pos;
                best  = lv[pos];
            end
        end
    end
`else
    logic unused_lvl;
    assign unused_lvl = ^lvl;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        pos   = '0;
        for (int k = 0; k < NUM_ACT; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= NUM_W) sum = sum - NUM_W;
            pos = sum[IDX_W-1:0];
            if (elig[pos] && !valid) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end
`endif
endmodule

// File: rtl/care_scheduler.sv
// Care-action scheduler: latches request pulses, issues one one-hot decrement pulse at a time,
// then waits COOL_TICKS prescaler ticks. CARE_URGENCY_PRIO_EN enables urgency-first selection.
module care_scheduler
    import care_pkg::*;
#(
    parameter int TICK_DIV   = 1000,
    parameter int COOL_TICKS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_ACT-1:0]        req,
    input  logic [NUM_ACT*STAT_W-1:0] stat_lvl,
    output logic [BUS_W-1:0]          act_out,
    output logic                      busy,
    output logic [NUM_ACT-1:0]        pending,
    output logic [IDX_W-1:0]          last_act
);
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CD_W = (COOL_TICKS > 0) ? $clog2(COOL_TICKS + 1) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COOL_TICKS);
    localparam logic [CD_W-1:0]  CD_ONE   = CD_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ACT - 1);

    state_t             state;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   rr_ptr;
    logic [PS_W-1:0]    prescaler;
    logic [CD_W-1:0]    cooldown;
    logic               tick;
    logic [NUM_ACT-1:0] nonzero;
    logic [NUM_ACT-1:0] eligible;
    logic [NUM_ACT-1:0] clr_mask;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;

    for (genvar g = 0; g < NUM_ACT; g++) begin : g_nz
        assign nonzero[g] = |stat_lvl[g*STAT_W +: STAT_W];
    end

    assign eligible = pending & nonzero;
    assign tick     = (prescaler == PS_LAST);

    // IDLE drops requests for exhausted stats; ISSUE retires the served one.
    always_comb begin
        clr_mask = '0;
        case (state)
            S_IDLE:  clr_mask = pending & ~nonzero;
            S_ISSUE: clr_mask = act_mask(sel);
            default: clr_mask = '0;
        endcase
    end

    care_rr_arbiter u_arb (
        .elig   (eligible),
        .rr_ptr (rr_ptr),
        .lvl    (stat_lvl),
        .valid  (pick_vld),
        .idx    (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            sel       <= '0;
            rr_ptr    <= '0;
            prescaler <= '0;
            cooldown  <= '0;
            act_out   <= '0;
            busy      <= 1'b0;
            pending   <= '0;
            last_act  <= ACT_NONE;
        end else begin
            prescaler <= tick ? '0 : prescaler + PS_W'(1);
            // New requests are OR-ed in after clearing so a same-cycle set wins.
            pending   <= (pending & ~clr_mask) | req;
            act_out   <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        sel     <= pick_idx;
                        act_out <= bus_onehot(pick_idx);
                        state   <= S_ISSUE;
                        busy    <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    last_act <= sel;
                    rr_ptr   <= (sel == IDX_LAST) ? '0 : sel + IDX_W'(1);
                    if (COOL_TICKS == 0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state    <= S_COOL;
                        cooldown <= CD_LOAD;
                    end
                end
                S_COOL: begin
                    if (tick) begin
                        if (cooldown <= CD_ONE) begin
                            cooldown <= '0;
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            cooldown <= cooldown - CD_ONE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
